// File: rtl/rv32i_types.sv
// Shared types for the L1-to-pmem arbiter: FSM states, grant owner and the default cacheline width.
package rv32i_types;

  localparam int CACHELINE_W = 256;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} arb_state_t;
  typedef enum logic {ARB_I, ARB_D} arb_owner_t;

endpackage

// File: rtl/arb_perf_counters.sv
// Grant and contention counters for the cache arbiter; only built when ARB_PERF_COUNTERS_EN is defined.
module arb_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_grant,
  input  logic        d_grant,
  input  logic        conflict,
  output logic [31:0] i_grants,
  output logic [31:0] d_grants,
  output logic [31:0] conflict_cycles
);

  // Free-running counters that wrap on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_grants        <= '0;
      d_grants        <= '0;
      conflict_cycles <= '0;
    end else begin
      if (i_grant)  i_grants        <= i_grants + 32'd1;
      if (d_grant)  d_grants        <= d_grants + 32'd1;
      if (conflict) conflict_cycles <= conflict_cycles + 32'd1;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one pmem port between the I-cache and D-cache.
// Optional perf counters are enabled with the ARB_PERF_COUNTERS_EN macro.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = CACHELINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0]       i_grants,
  output logic [31:0]       d_grants,
  output logic [31:0]       conflict_cycles
`endif
);

  arb_state_t        state, state_next;
  arb_owner_t        last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              i_req, d_req, grant_i, grant_d, serving;

  assign i_req        = i_read;
  assign d_req        = d_read | d_write;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ARB_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_i) begin
        addr_q     <= i_address;
        wdata_q    <= '0;
        write_q    <= 1'b0;
        last_grant <= ARB_I;
      end else if (grant_d) begin
        addr_q     <= d_address;
        wdata_q    <= d_wdata;
        write_q    <= d_write;
        last_grant <= ARB_D;
      end
    end
  end

  // A tie goes to whichever side was not granted last; pmem_resp only matters while serving.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    serving    = (state == SERVE_I) || (state == SERVE_D);
    pmem_read  = serving && !write_q;
    pmem_write = serving && write_q;
    i_resp     = (state == SERVE_I) && pmem_resp;
    d_resp     = (state == SERVE_D) && pmem_resp;
    i_rdata    = i_resp ? pmem_rdata : '0;
    d_rdata    = d_resp ? pmem_rdata : '0;
    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          if (last_grant == ARB_I) grant_d = 1'b1;
          else                     grant_i = 1'b1;
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
        if (grant_i)      state_next = SERVE_I;
        else if (grant_d) state_next = SERVE_D;
      end
      SERVE_I, SERVE_D: if (pmem_resp) state_next = RELEASE;
      RELEASE:          state_next = IDLE;
      default:          state_next = IDLE;
    endcase
  end

  a_no_read_and_write: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

`ifdef ARB_PERF_COUNTERS_EN
  arb_perf_counters u_perf (
    .clk             (clk),
    .rst             (rst),
    .i_grant         (grant_i),
    .d_grant         (grant_d),
    .conflict        (i_req && d_req),
    .i_grants        (i_grants),
    .d_grants        (d_grants),
    .conflict_cycles (conflict_cycles)
  );
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter; the perf-counter scenario runs when ARB_PERF_COUNTERS_EN is defined.
module tb_cache_arbiter;
  import rv32i_types::*;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, d_read, d_write, pmem_resp;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [LINE_W-1:0] d_wdata, pmem_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, pmem_wdata;
  logic              i_resp, d_resp, pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;
`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0]       i_grants, d_grants, conflict_cycles;
`endif

  int checkCount = 0;
  int passCount  = 0;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
`ifdef ARB_PERF_COUNTERS_EN
    ,
    .i_grants        (i_grants),
    .d_grants        (d_grants),
    .conflict_cycles (conflict_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic ir, input logic dr, input logic dw, input logic pr);
    i_read    = ir;
    d_read    = dr;
    d_write   = dw;
    pmem_resp = pr;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    i_address  = '0;
    d_address  = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("rst_state", 256'(dut.state), 256'(IDLE));
    checkOutput("rst_pmem_read", 256'(pmem_read), 256'd0);
    checkOutput("rst_pmem_write", 256'(pmem_write), 256'd0);
    checkOutput("rst_resps", 256'({i_resp, d_resp}), 256'd0);
    checkOutput("rst_pmem_address", 256'(pmem_address), 256'd0);
    nextCycle();
    rst = 1'b0;

    // I-cache alone: strobe one cycle later, fill returns after four serve cycles.
    i_address = 32'h0000_0060;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("i_alone_idle_read", 256'(pmem_read), 256'd0);
    nextCycle();
    checkOutput("i_alone_read", 256'(pmem_read), 256'd1);
    checkOutput("i_alone_addr", 256'(pmem_address), 256'h60);
    checkOutput("i_alone_no_resp", 256'(i_resp), 256'd0);
    nextCycle();
    nextCycle();
    checkOutput("i_alone_read_held", 256'(pmem_read), 256'd1);
    nextCycle();
    pmem_rdata = {32{8'hA5}};
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("i_alone_resp", 256'(i_resp), 256'd1);
    checkOutput("i_alone_rdata", i_rdata, {32{8'hA5}});
    checkOutput("i_alone_d_resp", 256'(d_resp), 256'd0);
    checkOutput("i_alone_d_rdata", d_rdata, 256'd0);
    checkOutput("i_alone_read_at_resp", 256'(pmem_read), 256'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("i_alone_release", 256'(dut.state), 256'(RELEASE));
    checkOutput("i_alone_release_read", 256'(pmem_read), 256'd0);
    nextCycle();
    checkOutput("i_alone_back_idle", 256'(dut.state), 256'(IDLE));

    // Ties: first after reset goes to D, then I, then D again.
    resetDut();
    i_address = 32'h0000_0100;
    d_address = 32'h0000_0200;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("tie1_state", 256'(dut.state), 256'(SERVE_D));
    checkOutput("tie1_addr", 256'(pmem_address), 256'h200);
    pmem_rdata = {32{8'h5A}};
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("tie1_d_resp", 256'(d_resp), 256'd1);
    checkOutput("tie1_d_rdata", d_rdata, {32{8'h5A}});
    checkOutput("tie1_i_resp", 256'(i_resp), 256'd0);
    checkOutput("tie1_i_rdata", i_rdata, 256'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("tie1_idle_read", 256'(pmem_read), 256'd0);
    nextCycle();
    checkOutput("tie1_then_i", 256'(dut.state), 256'(SERVE_I));
    checkOutput("tie1_then_i_addr", 256'(pmem_address), 256'h100);
    pmem_rdata = {32{8'hC3}};
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("tie1_i_rdata_fill", i_rdata, {32{8'hC3}});
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("tie2_state", 256'(dut.state), 256'(SERVE_D));
    checkOutput("tie2_addr", 256'(pmem_address), 256'h200);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("tie2_d_resp", 256'(d_resp), 256'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();

    // Writeback: latched address/data must hold while the cache inputs wander.
    d_address = 32'h8000_0020;
    d_wdata   = {8{32'h1234_5678}};
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("wb_write", 256'(pmem_write), 256'd1);
    checkOutput("wb_read", 256'(pmem_read), 256'd0);
    checkOutput("wb_addr", 256'(pmem_address), 256'h8000_0020);
    checkOutput("wb_wdata", pmem_wdata, {8{32'h1234_5678}});
    d_wdata   = ~{8{32'h1234_5678}};
    d_address = 32'hDEAD_0000;
    nextCycle();
    checkOutput("wb_wdata_held", pmem_wdata, {8{32'h1234_5678}});
    checkOutput("wb_addr_held", 256'(pmem_address), 256'h8000_0020);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("wb_resp", 256'(d_resp), 256'd1);
    checkOutput("wb_write_at_resp", 256'(pmem_write), 256'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("wb_release_write", 256'(pmem_write), 256'd0);
    nextCycle();

    // Stray pmem_resp in IDLE.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("stray_resps", 256'({i_resp, d_resp}), 256'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("stray_state", 256'(dut.state), 256'(IDLE));
    checkOutput("stray_strobes", 256'({pmem_read, pmem_write}), 256'd0);

    // Reset during SERVE_D aborts the transaction.
    d_address = 32'h0000_0040;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("abort_serving", 256'(pmem_read), 256'd1);
    pmem_resp = 1'b1;
    rst       = 1'b1;
    #1;
    checkOutput("abort_state", 256'(dut.state), 256'(IDLE));
    checkOutput("abort_read", 256'(pmem_read), 256'd0);
    checkOutput("abort_d_resp", 256'(d_resp), 256'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef ARB_PERF_COUNTERS_EN
    begin
      // Columns: i_read, d_read, pmem_resp. Yields 3 I grants, 2 D grants, 5 contended cycles.
      logic [2:0] perfSeq [15];
      perfSeq = '{3'b110, 3'b111, 3'b100, 3'b100, 3'b111, 3'b010, 3'b110, 3'b111,
                  3'b100, 3'b100, 3'b101, 3'b100, 3'b100, 3'b101, 3'b000};
      resetDut();
      #1;
      checkOutput("perf_rst_i", 256'(i_grants), 256'd0);
      checkOutput("perf_rst_conflict", 256'(conflict_cycles), 256'd0);
      for (int k = 0; k < 15; k++) begin
        applyStimulus(perfSeq[k][2], perfSeq[k][1], 1'b0, perfSeq[k][0]);
        nextCycle();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("perf_i_grants", 256'(i_grants), 256'd3);
      checkOutput("perf_d_grants", 256'(d_grants), 256'd2);
      checkOutput("perf_conflicts", 256'(conflict_cycles), 256'd5);
    end
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
